d_ff_delay_bank: RTL and testbench
==================================

Name: d_ff_delay_bank

Overview:
- Register bank for the online multiplier's digit-serial front end.
- Delays the redundant signed-digit pair (plus/minus strings, 4 bits each) by a fixed number of clock cycles.
- Holds a 2-bit control-state register with load enable, giving downstream select logic the previous-cycle STATES value.
- Pure storage: no arithmetic, no handshake.

Parameters:
- DIGIT_W, 4, width of each of the plus and minus digit strings.
- STATE_W, 2, width of the state register.
- DEPTH, 1, number of register stages on the digit path (legal range 1..8).

Ports:
- clk  input  1  rising-edge clock for all registers.
- rst_n  input  1  asynchronous active-low reset.
- x_plus_d  input  DIGIT_W  plus-digit string in.
- x_minus_d  input  DIGIT_W  minus-digit string in.
- x_plus_q  output  DIGIT_W  plus-digit string delayed DEPTH cycles.
- x_minus_q  output  DIGIT_W  minus-digit string delayed DEPTH cycles.
- state_d  input  STATE_W  current STATES value.
- state_en  input  1  load enable for the state register.
- state_q  output  STATE_W  registered state (previous STATES when state_en is held 1).

Behaviour:
Reset:
- rst_n low clears every stage immediately, independent of clk.
- During reset: x_plus_q, x_minus_q and state_q = 0.
- The reset state is identical whether reset arrives at power-up or mid-operation.
- Release is synchronous to the next rising clk edge: the first capture happens on the first rising edge with rst_n high.

Digit path:
- Unconditional shift on each rising edge.
- stage[0] <= x_plus_d / x_minus_d; stage[k] <= stage[k-1]; outputs = stage[DEPTH-1].
- Latency is exactly DEPTH cycles.
- Plus and minus paths are independent but always shift together.
- After reset release, the outputs read 0 until DEPTH edges have elapsed.
- No checking is done on the digit pair. Plus=minus=1 in the same bit position is passed through unchanged.

State path:
- Single stage.
- On a rising edge with state_en=1: state_q <= state_d.
- On a rising edge with state_en=0: state_q holds its value.
- rst_n low overrides state_en.

General:
- All outputs come directly from flops, with no combinational path from any input to any output.
- No X propagation from reset: every flop has a defined reset value.
- DEPTH outside 1..8 is an elaboration error (generate-time assertion).

Decomposition:
- Shared package mult_pkg: DIGIT_W_DEF=4 and STATE_W_DEF=2 constants, plus a typedef for the digit-pair struct {plus, minus}.
- One sub-module, dff_reg_en, with parameter W, async active-low reset and load enable. It is instantiated 2*DEPTH times on the digit path with enable tied to 1, and once for the state path with enable = state_en.

Test Plan:
- Reset mid-stream: drive x_plus_d=4'hA and x_minus_d=4'h5 for 3 cycles, then pulse rst_n low between edges → outputs go to 0 immediately, without waiting for an edge, and stay 0 for one edge after release.
- Latency with DEPTH=1: apply the sequence plus = 1,2,3,4 and minus = F,E,D,C, one value per edge → x_plus_q and x_minus_q show the same sequence shifted by exactly 1 cycle.
- DEPTH=3 build: apply the single value 4'h9 on plus → 9 appears on x_plus_q exactly 3 edges later; output is 0 before that.
- State enable: state_en=1, state_d = 00,01,10,11 → state_q lags by 1 cycle. Then hold state_en=0 and set state_d=01 → state_q stays 11.
- Redundant-digit pass-through: plus=4'hF, minus=4'hF → both outputs are F after the latency; nothing is masked.
- Reset priority: state_en=1 with state_d=10 while rst_n=0 → state_q remains 00 across the clock edge.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants and types for the online multiplier's digit-serial front end.
package mult_pkg;

   localparam int DIGIT_W_DEF = 4;
   localparam int STATE_W_DEF = 2;

   // Redundant signed-digit pair; plus and minus set in the same bit is legal.
   typedef struct packed {
      logic [DIGIT_W_DEF-1:0] plus;
      logic [DIGIT_W_DEF-1:0] minus;
   } digit_pair_t;

endpackage : mult_pkg

// File: rtl/d_ff_delay_bank_if.sv
// Digit-pair and state-register signals between the front end and the delay bank.
interface d_ff_delay_bank_if
   import mult_pkg::*;
#(
   parameter int DIGIT_W = DIGIT_W_DEF,
   parameter int STATE_W = STATE_W_DEF
) ();

   logic [DIGIT_W-1:0] x_plus_d;
   logic [DIGIT_W-1:0] x_minus_d;
   logic [DIGIT_W-1:0] x_plus_q;
   logic [DIGIT_W-1:0] x_minus_q;
   logic [STATE_W-1:0] state_d;
   logic               state_en;
   logic [STATE_W-1:0] state_q;

   modport master (
      output x_plus_d, x_minus_d, state_d, state_en,
      input  x_plus_q, x_minus_q, state_q
   );

   modport slave (
      input  x_plus_d, x_minus_d, state_d, state_en,
      output x_plus_q, x_minus_q, state_q
   );

endinterface : d_ff_delay_bank_if

// File: rtl/dff_reg_en.sv
// W-bit register with asynchronous active-low clear and load enable.
module dff_reg_en #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // NOTE: non-blocking assignment keeps chained stages shifting by exactly one
   // position per edge, and the async clear gives every flop a defined value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule : dff_reg_en

// File: rtl/d_ff_delay_bank.sv
// Fixed-latency delay line for the digit pair plus an enabled state register.
module d_ff_delay_bank
   import mult_pkg::*;
#(
   parameter int DIGIT_W = DIGIT_W_DEF,
   parameter int STATE_W = STATE_W_DEF,
   parameter int DEPTH   = 1
) (
   input logic               clk,
   input logic               rst_n,
   d_ff_delay_bank_if.slave  bus
);

   if (DEPTH < 1 || DEPTH > 8) begin : g_depth_check
      $error("d_ff_delay_bank: DEPTH must be in 1..8");
   end

   logic [DIGIT_W-1:0] plus_stage  [DEPTH];
   logic [DIGIT_W-1:0] minus_stage [DEPTH];

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic [DIGIT_W-1:0] plus_in;
      logic [DIGIT_W-1:0] minus_in;

      if (k == 0) begin : g_head
         assign plus_in  = bus.x_plus_d;
         assign minus_in = bus.x_minus_d;
      end else begin : g_tail
         assign plus_in  = plus_stage[k-1];
         assign minus_in = minus_stage[k-1];
      end

      dff_reg_en #(.W(DIGIT_W)) u_plus (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (1'b1),
         .d     (plus_in),
         .q     (plus_stage[k])
      );

      dff_reg_en #(.W(DIGIT_W)) u_minus (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (1'b1),
         .d     (minus_in),
         .q     (minus_stage[k])
      );
   end

   assign bus.x_plus_q  = plus_stage[DEPTH-1];
   assign bus.x_minus_q = minus_stage[DEPTH-1];

   // Downstream select logic sees the previous-cycle state value.
   dff_reg_en #(.W(STATE_W)) u_state (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (bus.state_en),
      .d     (bus.state_d),
      .q     (bus.state_q)
   );

endmodule : d_ff_delay_bank

// File: tb/tb_d_ff_delay_bank.sv
// Self-checking bench: DEPTH=1 and DEPTH=3 banks against a digit-pair scoreboard.
module tb_d_ff_delay_bank;
   import mult_pkg::*;

   logic clk;
   logic rst_n;

   int n_checks = 0;
   int n_fail   = 0;

   digit_pair_t q1[$];
   digit_pair_t q3[$];
   logic [1:0]  exp_state;

   d_ff_delay_bank_if #(.DIGIT_W(4), .STATE_W(2)) bus1 ();
   d_ff_delay_bank_if #(.DIGIT_W(4), .STATE_W(2)) bus3 ();

   d_ff_delay_bank #(.DIGIT_W(4), .STATE_W(2), .DEPTH(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   d_ff_delay_bank #(.DIGIT_W(4), .STATE_W(2), .DEPTH(3)) dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " d1 plus"},  32'(bus1.x_plus_q),  32'h0);
      check({tag, " d1 minus"}, 32'(bus1.x_minus_q), 32'h0);
      check({tag, " d3 plus"},  32'(bus3.x_plus_q),  32'h0);
      check({tag, " d3 minus"}, 32'(bus3.x_minus_q), 32'h0);
      check({tag, " state"},    32'(bus1.state_q),   32'h0);
   endtask

   // After reset both banks read zero until their latency has elapsed.
   task automatic init_scoreboard();
      digit_pair_t z;
      z = '0;
      q1.delete();
      q3.delete();
      q1.push_back(z);
      for (int i = 0; i < 3; i++) q3.push_back(z);
      exp_state = 2'b00;
   endtask

   task automatic drive(input logic [3:0] p, input logic [3:0] m,
                        input logic [1:0] sd, input logic en);
      bus1.x_plus_d  = p;  bus1.x_minus_d = m;
      bus3.x_plus_d  = p;  bus3.x_minus_d = m;
      bus1.state_d   = sd; bus1.state_en  = en;
      bus3.state_d   = sd; bus3.state_en  = en;
   endtask

   // Called at a falling edge: compare current outputs, drive next input, clock.
   task automatic step(input string tag, input logic [3:0] p, input logic [3:0] m,
                       input logic [1:0] sd, input logic en);
      digit_pair_t e;
      digit_pair_t v;
      if (q1.size() == 0) begin
         check({tag, " d1 scoreboard empty"}, 32'h1, 32'h0);
      end else begin
         e = q1.pop_front();
         check({tag, " d1 plus"},  32'(bus1.x_plus_q),  32'(e.plus));
         check({tag, " d1 minus"}, 32'(bus1.x_minus_q), 32'(e.minus));
      end
      if (q3.size() == 0) begin
         check({tag, " d3 scoreboard empty"}, 32'h1, 32'h0);
      end else begin
         e = q3.pop_front();
         check({tag, " d3 plus"},  32'(bus3.x_plus_q),  32'(e.plus));
         check({tag, " d3 minus"}, 32'(bus3.x_minus_q), 32'(e.minus));
      end
      check({tag, " state"}, 32'(bus1.state_q), 32'(exp_state));

      drive(p, m, sd, en);
      v.plus  = p;
      v.minus = m;
      q1.push_back(v);
      q3.push_back(v);
      @(posedge clk);
      if (en) exp_state = sd;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      drive(4'h0, 4'h0, 2'b00, 1'b0);
      #3;
      check_all_zero("power-up reset");
      @(negedge clk);
      rst_n = 1'b1;
      init_scoreboard();

      // Stream A/5, then pulse reset between edges.
      for (int i = 0; i < 3; i++) step("stream A5", 4'hA, 4'h5, 2'b00, 1'b0);
      check("pre-reset d1 plus", 32'(bus1.x_plus_q), 32'hA);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async reset");
      // Reset must override a pending state load across the edge.
      drive(4'hA, 4'h5, 2'b10, 1'b1);
      @(posedge clk);
      #1;
      check_all_zero("reset across edge");
      @(negedge clk);
      rst_n = 1'b1;
      init_scoreboard();

      // Latency sequence with state loads 00,01,10,11.
      step("seq0", 4'h1, 4'hF, 2'b00, 1'b1);
      step("seq1", 4'h2, 4'hE, 2'b01, 1'b1);
      step("seq2", 4'h3, 4'hD, 2'b10, 1'b1);
      step("seq3", 4'h4, 4'hC, 2'b11, 1'b1);

      // Single 9 on plus with state load disabled; state must hold 11.
      step("pulse9", 4'h9, 4'h0, 2'b01, 1'b0);
      for (int i = 0; i < 4; i++) step("after9", 4'h0, 4'h0, 2'b01, 1'b0);
      check("state held", 32'(bus1.state_q), 32'h3);

      // Redundant pair with both digits set passes through unmasked.
      step("redundant", 4'hF, 4'hF, 2'b01, 1'b0);
      for (int i = 0; i < 4; i++) step("drain", 4'h0, 4'h0, 2'b10, 1'b1);
      step("final", 4'h0, 4'h0, 2'b10, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_d_ff_delay_bank
